// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and the ownership decision for the data-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_t;

   // Decide who owns memory next cycle from the current owner, the previous
   // owner (tie-break) and both requesters' req/lock inputs.
   function automatic owner_t next_owner(
      input owner_t owner,
      input owner_t last,
      input logic   cpu_req,
      input logic   cpu_lock,
      input logic   ext_req,
      input logic   ext_lock,
      input logic   at_max
   );
      owner_t other;
      logic   own_req;
      logic   own_lock;
      logic   oth_req;
      owner_t result;
      result = owner;
      case (owner)
         OWN_CPU: begin
            other    = OWN_EXT;
            own_req  = cpu_req;
            own_lock = cpu_lock;
            oth_req  = ext_req;
         end
         OWN_EXT: begin
            other    = OWN_CPU;
            own_req  = ext_req;
            own_lock = ext_lock;
            oth_req  = cpu_req;
         end
         default: begin
            other    = OWN_IDLE;
            own_req  = 1'b0;
            own_lock = 1'b0;
            oth_req  = 1'b0;
         end
      endcase
      if (owner == OWN_CPU || owner == OWN_EXT) begin
         if (!own_req) begin
            result = oth_req ? other : OWN_IDLE;
         end else if (oth_req && (!own_lock || at_max)) begin
            result = other;
         end else begin
            result = owner;
         end
      end else begin
         // Idle: a lone requester wins, a tie goes to whoever did not own last.
         if (cpu_req && ext_req) begin
            result = (last == OWN_CPU) ? OWN_EXT : OWN_CPU;
         end else if (cpu_req) begin
            result = OWN_CPU;
         end else if (ext_req) begin
            result = OWN_EXT;
         end else begin
            result = OWN_IDLE;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the CPU port, EXT port and DataMemory port around the arbiter.
interface data_mem_arbiter_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) ();

   logic                     cpu_req;
   logic                     cpu_we;
   logic                     cpu_lock;
   logic [ADDRESS_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0]    cpu_wdata;
   logic                     cpu_gnt;
   logic                     cpu_rvalid;
   logic [DATA_WIDTH-1:0]    cpu_rdata;
   logic                     cpu_stall;

   logic                     ext_req;
   logic                     ext_we;
   logic                     ext_lock;
   logic [ADDRESS_WIDTH-1:0] ext_addr;
   logic [DATA_WIDTH-1:0]    ext_wdata;
   logic                     ext_gnt;
   logic                     ext_rvalid;
   logic [DATA_WIDTH-1:0]    ext_rdata;

   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]    mem_wd;
   logic [DATA_WIDTH-1:0]    mem_rd;

   // Arbiter side.
   modport slave (
      input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_we, mem_addr, mem_wd,
      input  mem_rd
   );

   // Requesters plus memory side.
   modport master (
      output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_we, mem_addr, mem_wd,
      output mem_rd
   );

endinterface

// File: rtl/data_mem_arbiter_burst_counter.sv
// Counts consecutive cycles the current owner has kept memory; flags the
// last cycle a locked owner may hold it while the other side waits.
module arb_burst_counter #(
   parameter int MAX_BURST = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic inc_i,
   output logic at_max_o
);

   localparam int            CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over increment; increment saturates at the burst limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port DataMemory between the CPU load/store path and the
// EXT loader/debug port. Ownership is registered, so grants never depend
// combinationally on the requests; reads return one cycle after the grant.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_BURST     = 8
) (
   input  logic                clk,
   input  logic                rst,
   data_mem_arbiter_if.slave   bus
);

   owner_t                   owner_q;
   owner_t                   owner_d;
   owner_t                   last_q;
   owner_t                   last_d;
   logic                     cnt_clear;
   logic                     cnt_inc;
   logic                     at_max;

   logic                     own_req;
   logic                     own_we;
   logic [ADDRESS_WIDTH-1:0] own_addr;
   logic [DATA_WIDTH-1:0]    own_wd;
   logic                     cpu_read;
   logic                     ext_read;

   logic                     cpu_rvalid_q;
   logic                     ext_rvalid_q;
   logic [DATA_WIDTH-1:0]    cpu_rdata_q;
   logic [DATA_WIDTH-1:0]    ext_rdata_q;

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burst (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (cnt_clear),
      .inc_i    (cnt_inc),
      .at_max_o (at_max)
   );

   // Next owner, tie-break history and burst counter control.
   always_comb begin
      owner_d = next_owner(owner_q, last_q, bus.cpu_req, bus.cpu_lock,
                           bus.ext_req, bus.ext_lock, at_max);
      last_d  = last_q;
      if ((owner_d != owner_q) && (owner_q != OWN_IDLE)) begin
         last_d = owner_q;
      end
      cnt_clear = (owner_d != owner_q) || (owner_d == OWN_IDLE);
      cnt_inc   = ~cnt_clear;
   end

   // Owner and last-owner registers; after reset the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_IDLE;
         last_q  <= OWN_EXT;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Route the owning requester onto the memory port; idle drives zeros.
   always_comb begin
      own_req  = 1'b0;
      own_we   = 1'b0;
      own_addr = '0;
      own_wd   = '0;
      case (owner_q)
         OWN_CPU: begin
            own_req  = bus.cpu_req;
            own_we   = bus.cpu_we;
            own_addr = bus.cpu_addr;
            own_wd   = bus.cpu_wdata;
         end
         OWN_EXT: begin
            own_req  = bus.ext_req;
            own_we   = bus.ext_we;
            own_addr = bus.ext_addr;
            own_wd   = bus.ext_wdata;
         end
         default: begin
         end
      endcase
   end

   assign cpu_read = (owner_q == OWN_CPU) && own_req && !own_we;
   assign ext_read = (owner_q == OWN_EXT) && own_req && !own_we;

   // Capture read data at the end of the granted cycle; rdata holds until
   // the next read by the same requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid_q <= 1'b0;
         ext_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         ext_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= cpu_read;
         ext_rvalid_q <= ext_read;
         if (cpu_read) begin
            cpu_rdata_q <= bus.mem_rd;
         end
         if (ext_read) begin
            ext_rdata_q <= bus.mem_rd;
         end
      end
   end

   // A write in a reset cycle is dropped.
   assign bus.mem_we     = own_req & own_we & ~rst;
   assign bus.mem_addr   = own_addr;
   assign bus.mem_wd     = own_wd;

   assign bus.cpu_gnt    = (owner_q == OWN_CPU);
   assign bus.ext_gnt    = (owner_q == OWN_EXT);
   assign bus.cpu_stall  = bus.cpu_req & (owner_q != OWN_CPU);
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.ext_rvalid = ext_rvalid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed bench for data_mem_arbiter with a behavioural
// ownership/memory model and a read-return scoreboard.
module tb_data_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXB = 8;

   logic clk = 1'b0;
   logic rst;
   bit   chk_en = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   data_mem_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .MAX_BURST     (MAXB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] init_word(input int idx);
      if (idx == 4) return 32'hDEADBEEF;       // byte address 0x10
      return 32'hC0DE0000 + idx;
   endfunction

   // DataMemory stand-in: combinational read, write on rising edge.
   logic [31:0] dmem [0:63];
   bit   [63:0] dmem_wr;
   logic [5:0]  dmem_idx;
   assign dmem_idx   = bus.mem_addr[7:2];
   assign bus.mem_rd = dmem_wr[dmem_idx] ? dmem[dmem_idx] : init_word(int'(dmem_idx));
   always @(posedge clk) begin
      if (bus.mem_we) begin
         dmem[dmem_idx]    <= bus.mem_wd;
         dmem_wr[dmem_idx] <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Reference model: memory contents, owner (0 idle, 1 cpu, 2 ext), etc.
   logic [31:0] refmem [0:63];
   bit   [63:0] ref_wr;
   int          m_owner = 0;
   int          m_last  = 2;
   int          m_cnt   = 0;
   logic [31:0] m_cpu_rdata = 0;
   logic [31:0] m_ext_rdata = 0;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          when;
   } exp_t;
   exp_t exp_q[$];

   always @(negedge clk) begin
      if (chk_en) begin
         bit          oreq, owe, olock, othreq;
         logic [31:0] oaddr, owd, rd;
         int          idx, nxt, oth;
         oreq = 0; owe = 0; olock = 0; othreq = 0; oaddr = 0; owd = 0;
         if (m_owner == 1) begin
            oreq = bus.cpu_req; owe = bus.cpu_we; olock = bus.cpu_lock;
            oaddr = bus.cpu_addr; owd = bus.cpu_wdata; othreq = bus.ext_req;
         end else if (m_owner == 2) begin
            oreq = bus.ext_req; owe = bus.ext_we; olock = bus.ext_lock;
            oaddr = bus.ext_addr; owd = bus.ext_wdata; othreq = bus.cpu_req;
         end
         chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(m_owner == 1));
         chk("ext_gnt", 32'(bus.ext_gnt), 32'(m_owner == 2));
         chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && m_owner != 1));
         chk("mem_we", 32'(bus.mem_we), 32'(oreq && owe && !rst));
         chk("mem_addr", bus.mem_addr, oaddr);
         chk("mem_wd", bus.mem_wd, owd);
         chk("cpu_rdata", bus.cpu_rdata, m_cpu_rdata);
         chk("ext_rdata", bus.ext_rdata, m_ext_rdata);

         if (rst) begin
            m_owner = 0; m_last = 2; m_cnt = 0;
            m_cpu_rdata = 0; m_ext_rdata = 0;
         end else begin
            idx = int'(oaddr[7:2]);
            if (oreq && owe) begin
               refmem[idx] = owd;
               ref_wr[idx] = 1'b1;
            end else if (oreq) begin
               rd = ref_wr[idx] ? refmem[idx] : init_word(idx);
               exp_q.push_back('{port: m_owner, data: rd, when: cyc + 1});
               if (m_owner == 1) m_cpu_rdata = rd;
               else              m_ext_rdata = rd;
            end
            if (m_owner == 0) begin
               if (bus.cpu_req && bus.ext_req) nxt = 3 - m_last;
               else if (bus.cpu_req)           nxt = 1;
               else if (bus.ext_req)           nxt = 2;
               else                            nxt = 0;
            end else begin
               oth = 3 - m_owner;
               if (!oreq)                                        nxt = othreq ? oth : 0;
               else if (othreq && (!olock || m_cnt == MAXB - 1)) nxt = oth;
               else                                              nxt = m_owner;
            end
            if (nxt != m_owner && m_owner != 0) m_last = m_owner;
            if (nxt == m_owner && nxt != 0) m_cnt = (m_cnt + 1 > MAXB - 1) ? MAXB - 1 : m_cnt + 1;
            else                            m_cnt = 0;
            m_owner = nxt;
         end
      end
   end

   // Read-return monitor.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         if (bus.cpu_rvalid || bus.ext_rvalid) begin
            if (exp_q.size() == 0) begin
               chk("rvalid_unexpected", {30'd0, bus.ext_rvalid, bus.cpu_rvalid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rvalid_port", {30'd0, bus.ext_rvalid, bus.cpu_rvalid},
                   (e.port == 1) ? 32'd1 : 32'd2);
               chk("rvalid_cycle", 32'(cyc), 32'(e.when));
               chk("rdata", (e.port == 1) ? bus.cpu_rdata : bus.ext_rdata, e.data);
            end
         end else if (exp_q.size() > 0 && exp_q[0].when <= cyc) begin
            e = exp_q.pop_front();
            chk("rvalid_missing", 32'd0, 32'd1);
         end
      end
   end

   task automatic drive(input bit cr, input bit cw, input bit cl,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input bit er, input bit ew, input bit el,
                        input logic [31:0] ea, input logic [31:0] ed);
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_lock = cl;
      bus.cpu_addr = ca; bus.cpu_wdata = cd;
      bus.ext_req = er; bus.ext_we = ew; bus.ext_lock = el;
      bus.ext_addr = ea; bus.ext_wdata = ed;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   initial begin
      int stall_n;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      // CPU read of 0x10 held until granted.
      drive(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0); tick();
      idle(3);

      // Fresh reset, then both request unlocked: CPU first, then alternate.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 32'h04, 0, 1, 0, 0, 32'h08, 0);
         tick();
      end
      idle(3);

      // Locked EXT burst of 12 writes; CPU waits for exactly MAXB cycles.
      stall_n = 0;
      for (int i = 0; i < 14; i++) begin
         drive(i >= 1 && i <= 9, 0, 0, 32'h44, 0,
               i < 12, 1, 1, 32'h40 + 32'(4 * i), $urandom);
         #2;
         if (bus.cpu_stall) stall_n++;
         tick();
      end
      chk("burst_stall_cycles", 32'(stall_n), 32'(MAXB));
      idle(3);

      // EXT writes 0x20, CPU reads it back.
      drive(0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 32'h12345678); tick();
      drive(0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 32'h12345678); tick();
      drive(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0); tick();
      idle(3);

      // Reset lands on a granted CPU write: write dropped.
      drive(1, 1, 0, 32'h30, 32'hAAAA5555, 0, 0, 0, 0, 0); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      idle(2);
      drive(1, 0, 0, 32'h30, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 32'h30, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 32'h30, 0, 0, 0, 0, 0, 0); tick();
      idle(3);

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
         tick();
      end
      rst = 1'b0;
      idle(5);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
